timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped timer/counter device on the CPU data port. Sits directly downstream of the `mips` core's `m_data_*` interface, behind the address bridge that decodes the timer window. Software programs a preset and control word; the block counts down and raises an interrupt request to the core. Supports one-shot and auto-reload modes.

## Interface
- `RESET_PRESET`, default 32'h0: value loaded into PRESET at reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `addr`  in  32  byte address from `m_data_addr`; only `addr[3:2]` decoded.
- `we`  in  1  write strobe; asserted by the bridge when the address hits this window and `m_data_byteen != 0`.
- `byteen`  in  4  byte enables from `m_data_byteen`; bit i enables `wdata[8i+7:8i]`.
- `wdata`  in  32  write data from `m_data_wdata`.
- `rdata`  out  32  combinational read data for the addressed register.
- `irq`  out  1  interrupt request to the core.

## Operation
- Register map (`addr[3:2]`):
  - 0 CTRL: bit0 EN, bits2:1 MODE, bit3 IM; bits31:4 read 0, writes ignored.
  - 1 PRESET: reload value, read/write.
  - 2 COUNT: current count, read-only; writes ignored.
  - 3 reserved: reads 0, writes ignored.
- Writes byte-merged: only enabled bytes change; `byteen == 0` has no effect.
- MODE 0 = one-shot, MODE 1 = auto-reload; MODE 2/3 treated as MODE 0.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go LOAD; else stay.
  - LOAD: COUNT <= PRESET; go CNT.
  - CNT: if !EN go IDLE (COUNT holds). Else if COUNT <= 1: COUNT <= 0, go INT, set irq_flag. Else COUNT <= COUNT-1.
  - INT: MODE 0: clear EN, go IDLE, irq_flag stays set. MODE 1: go IDLE, clear irq_flag (EN still 1, so reload follows).
- irq_flag cleared by any write to CTRL or PRESET.
- `irq` = IM & irq_flag.
- Reset values: CTRL 0, PRESET `RESET_PRESET`, COUNT 0, state IDLE, irq_flag 0, `irq` 0, `rdata` = value of addressed register after reset.

## Timing
- Register write at edge E0 is visible on `rdata` after E0.
- EN written at E0: LOAD after E1, COUNT = PRESET after E2, INT and irq_flag set after E(N+2) for PRESET = N ≥ 1; PRESET 0 behaves as 1.
- MODE 1 period: N+3 cycles between irq pulses; pulse width 1 cycle.
- Simultaneous software CTRL write and INT-state EN clear: the software write wins.
- Simultaneous write and irq_flag set: the clear wins.
- PRESET written during CNT takes effect only at the next LOAD.
- Reset asserted mid-count: all state cleared asynchronously; counting resumes only after EN is rewritten.

## Configuration
- `TIMER_IRQ_EN` defined: irq_flag, the IM bit and `irq` behave as above.
- Not defined:
  - `irq` tied 0.
  - IM bit reads 0 and ignores writes.
  - irq_flag logic removed.
  - Counting and mode behaviour are unchanged.

## Structure
- Shared package `timer_pkg`:
  - state encoding (IDLE/LOAD/CNT/INT);
  - register offsets;
  - CTRL bit positions;
  - MODE constants.
- Sub-module `timer_byte_merge` (old word, wdata, byteen -> merged word), instantiated for CTRL and PRESET.

## Test plan
- Reset with `RESET_PRESET`=0: `irq`=0, CTRL reads 0, COUNT reads 0, state IDLE.
- PRESET=5; write CTRL=0x9 (EN, MODE 0, IM) at E0 -> `irq` rises after E7, COUNT=0, CTRL reads 0x8. Write CTRL=0 -> `irq` falls next cycle.
- PRESET=3; CTRL=0xB (auto-reload, IM) -> one-cycle `irq` pulses every 6 cycles, COUNT sequence 3,2,1,0.
- Write CTRL EN=0 while COUNT=4 in CNT -> count freezes at 4, no `irq`. Re-enable -> reload from PRESET.
- PRESET write with byteen=4'b0010, wdata=32'hAABBCCDD, old 0 -> PRESET reads 32'h0000CC00. Write to COUNT -> no change.
- Assert `reset` mid-count with COUNT=7 -> all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer_counter block: FSM states, register map, CTRL layout and modes.
package timer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCnt,
        StInt
    } timer_state_e;

    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegPreset = 2'd1;
    localparam logic [1:0] RegCount  = 2'd2;
    localparam logic [1:0] RegRsvd   = 2'd3;

    localparam int unsigned CtrlEnBit   = 0;
    localparam int unsigned CtrlModeLsb = 1;
    localparam int unsigned CtrlImBit   = 3;

    localparam logic [1:0] ModeOneShot = 2'd0;
    localparam logic [1:0] ModeReload  = 2'd1;

    // Only MODE 1 reloads; the two unused encodings fall back to one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == ModeReload;
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Data-port bus between the address bridge (master) and the timer (slave).
interface timer_counter_if;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, we, byteen, wdata, input rdata, irq);
    modport slave  (input addr, we, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/timer_byte_merge.sv
// Byte-enable merge: enabled bytes take wdata, the rest keep the old word.
module timer_byte_merge #(
    parameter int unsigned Width = 32,
    localparam int unsigned NumBytes = (Width + 7) / 8
) (
    input  logic [Width-1:0]    old_i,
    input  logic [Width-1:0]    wdata_i,
    input  logic [NumBytes-1:0] byteen_i,
    output logic [Width-1:0]    merged_o
);
    for (genvar b = 0; b < NumBytes; b++) begin : g_byte
        localparam int unsigned Lsb = 8 * b;
        localparam int unsigned W   = (Width - Lsb < 8) ? Width - Lsb : 8;
        assign merged_o[Lsb +: W] = byteen_i[b] ? wdata_i[Lsb +: W] : old_i[Lsb +: W];
    end
endmodule

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Interrupt path (IM bit, irq_flag, irq) present only when TIMER_IRQ_EN is defined.
module timer_counter
    import timer_pkg::*;
#(
    parameter logic [31:0] RESET_PRESET = 32'h0
) (
    input logic            clk,
    input logic            reset,
    timer_counter_if.slave bus
);
    timer_state_e state_q;
    logic [3:0]   ctrl_q;
    logic [31:0]  preset_q;
    logic [31:0]  count_q;

    logic [3:0]  ctrl_merged;
    logic [3:0]  ctrl_d;
    logic [31:0] preset_merged;
    logic        wr_hit;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        ctrl_en;
    logic        reload;
    logic        unused_addr;

    assign wr_hit    = bus.we && (bus.byteen != 4'b0000);
    assign wr_ctrl   = wr_hit && (bus.addr[3:2] == RegCtrl);
    assign wr_preset = wr_hit && (bus.addr[3:2] == RegPreset);
    assign ctrl_en   = ctrl_q[CtrlEnBit];
    assign reload    = is_reload(ctrl_q[CtrlModeLsb +: 2]);

    assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

    timer_byte_merge #(.Width(4)) u_ctrl_merge (
        .old_i   (ctrl_q),
        .wdata_i (bus.wdata[3:0]),
        .byteen_i(bus.byteen[0]),
        .merged_o(ctrl_merged)
    );

    timer_byte_merge #(.Width(32)) u_preset_merge (
        .old_i   (preset_q),
        .wdata_i (bus.wdata),
        .byteen_i(bus.byteen),
        .merged_o(preset_merged)
    );

`ifdef TIMER_IRQ_EN
    assign ctrl_d = ctrl_merged;
`else
    logic unused_im;
    assign unused_im = ctrl_merged[CtrlImBit];
    assign ctrl_d    = {1'b0, ctrl_merged[2:0]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ctrl_q   <= '0;
            preset_q <= RESET_PRESET;
            count_q  <= '0;
        end else begin
            if (wr_preset) preset_q <= preset_merged;
            unique case (state_q)
                StIdle: if (ctrl_en) state_q <= StLoad;
                StLoad: begin
                    count_q <= preset_q;
                    state_q <= StCnt;
                end
                StCnt: begin
                    if (!ctrl_en) begin
                        state_q <= StIdle;
                    end else if (count_q <= 32'd1) begin
                        count_q <= '0;
                        state_q <= StInt;
                    end else begin
                        count_q <= count_q - 32'd1;
                    end
                end
                StInt: begin
                    state_q <= StIdle;
                    if (!reload) ctrl_q[CtrlEnBit] <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
            // A software CTRL write in the same cycle overrides the one-shot EN clear.
            if (wr_ctrl) ctrl_q <= ctrl_d;
        end
    end

`ifdef TIMER_IRQ_EN
    logic irq_flag_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_flag_q <= 1'b0;
        end else if (wr_ctrl || wr_preset) begin
            irq_flag_q <= 1'b0;
        end else if (state_q == StCnt && ctrl_en && count_q <= 32'd1) begin
            irq_flag_q <= 1'b1;
        end else if (state_q == StInt && reload) begin
            irq_flag_q <= 1'b0;
        end
    end

    assign bus.irq = ctrl_q[CtrlImBit] & irq_flag_q;
`else
    assign bus.irq = 1'b0;
`endif

    always_comb begin
        bus.rdata = '0;
        unique case (bus.addr[3:2])
            RegCtrl:   bus.rdata = {28'd0, ctrl_q};
            RegPreset: bus.rdata = preset_q;
            RegCount:  bus.rdata = count_q;
            default:   bus.rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed scenarios plus random register traffic, checked every
// cycle against a timeline model (cycles since EN was seen) of the counter.
module tb_timer_counter;
`ifdef TIMER_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif
    localparam logic [3:0] CtrlMask = IrqEn ? 4'hF : 4'h7;

    logic clk;
    logic reset;
    timer_counter_if bus ();

    timer_counter #(.RESET_PRESET(32'h0)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp;
    int n_bad;

    // Reference model: m_t = -1 when idle, 0 while loading, k >= 1 = k-th cycle since load.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic [31:0] m_load;
    logic        m_flag;
    int          m_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_reg(input int r);
        case (r)
            0:       return {28'd0, m_ctrl};
            1:       return m_preset;
            2:       return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expire(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s: wait bound expired, observed=no event expected=event", tag);
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_preset = '0; m_count = '0; m_load = '0; m_flag = 1'b0; m_t = -1;
    endtask

    task automatic model_edge();
        logic hit, wc, wp, en, rel, clr_en;
        logic [3:0] nctrl;
        int eff;
        hit    = bus.we && (bus.byteen != 4'd0);
        wc     = hit && (bus.addr[3:2] == 2'd0);
        wp     = hit && (bus.addr[3:2] == 2'd1);
        nctrl  = bus.byteen[0] ? bus.wdata[3:0] : m_ctrl;
        en     = m_ctrl[0];
        rel    = (m_ctrl[2:1] == 2'd1);
        clr_en = 1'b0;
        eff    = (m_load == 32'd0) ? 1 : int'(m_load);
        if (m_t < 0) begin
            if (en) m_t = 0;
        end else if (m_t == 0) begin
            m_load = m_preset; m_count = m_preset; m_t = 1;
        end else if (m_t <= eff) begin
            if (!en) m_t = -1;
            else begin
                m_t++;
                if (m_t - 1 >= eff) begin
                    m_count = 32'd0; m_flag = IrqEn;
                end else m_count = m_load - 32'(m_t - 1);
            end
        end else begin
            m_t = -1;
            if (rel) m_flag = 1'b0;
            else clr_en = 1'b1;
        end
        if (clr_en) m_ctrl[0] = 1'b0;
        if (wc) m_ctrl = nctrl & CtrlMask;
        if (wp) m_preset = merge(m_preset, bus.wdata, bus.byteen);
        if (wc || wp) m_flag = 1'b0;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        bus.we = 1'b0;
        bus.byteen = 4'd0;
        chk({tag, " irq"}, {31'd0, bus.irq}, {31'd0, IrqEn & m_ctrl[3] & m_flag});
        for (int r = 0; r < 4; r++) begin
            bus.addr = 32'(r) << 2;
            #1;
            chk($sformatf("%s reg%0d", tag, r), bus.rdata, exp_reg(r));
        end
    endtask

    task automatic wr(input logic [1:0] r, input logic [3:0] be, input logic [31:0] d,
                      input string tag);
        logic [31:0] a;
        a = $urandom;
        a[3:2] = r;
        bus.addr = a; bus.we = 1'b1; bus.byteen = be; bus.wdata = d;
        tick(tag);
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) tick(tag);
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] v);
        bus.addr = {28'd0, r, 2'b00};
        #1;
        v = bus.rdata;
    endtask

    initial begin
        logic [31:0] v;
        int pulses[$];
        int waited;
        logic [1:0] r;
        logic [3:0] be;
        logic [31:0] d;

        n_cmp = 0; n_bad = 0;
        model_reset();
        reset = 1'b1;
        bus.addr = '0; bus.we = 1'b0; bus.byteen = '0; bus.wdata = '0;
        #1;
        chk("reset irq", {31'd0, bus.irq}, 32'd0);
        rd(2'd0, v); chk("reset ctrl", v, 32'd0);
        rd(2'd1, v); chk("reset preset", v, 32'd0);
        rd(2'd2, v); chk("reset count", v, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // One-shot, PRESET 5.
        wr(2'd1, 4'hF, 32'd5, "os preset");
        wr(2'd0, 4'hF, 32'h9, "os E0");
        idle(6, "os");
        chk("os irq before E7", {31'd0, bus.irq}, 32'd0);
        tick("os E7");
        chk("os irq at E7", {31'd0, bus.irq}, {31'd0, IrqEn});
        rd(2'd2, v); chk("os count at E7", v, 32'd0);
        tick("os E8");
        rd(2'd0, v); chk("os ctrl after INT", v, {28'd0, 4'h8 & CtrlMask});
        wr(2'd0, 4'hF, 32'h0, "os clr");
        chk("os irq after clr", {31'd0, bus.irq}, 32'd0);

        // Auto-reload, PRESET 3.
        wr(2'd1, 4'hF, 32'd3, "ar preset");
        wr(2'd0, 4'hF, 32'hB, "ar E0");
        for (int i = 0; i < 24; i++) begin
            tick("ar");
            if (bus.irq) pulses.push_back(i);
        end
        chk("ar pulse count", 32'(pulses.size()), IrqEn ? 32'd4 : 32'd0);
        for (int i = 1; i < pulses.size(); i++)
            chk("ar pulse spacing", 32'(pulses[i] - pulses[i-1]), 32'd6);
        wr(2'd0, 4'hF, 32'h0, "ar stop");
        idle(3, "ar idle");

        // Disable mid-count so the count freezes at 4, then re-enable.
        wr(2'd1, 4'hF, 32'd9, "fz preset");
        wr(2'd0, 4'hF, 32'h1, "fz en");
        waited = 0;
        while (!(m_t >= 1 && m_count == 32'd5) && waited < 30) begin
            tick("fz wait");
            waited++;
        end
        if (waited >= 30) expire("fz wait count5");
        wr(2'd0, 4'hF, 32'h0, "fz dis");
        idle(3, "fz hold");
        rd(2'd2, v); chk("fz frozen count", v, 32'd4);
        chk("fz irq", {31'd0, bus.irq}, 32'd0);
        wr(2'd0, 4'hF, 32'h1, "fz reen");
        idle(2, "fz reload");
        rd(2'd2, v); chk("fz reloaded count", v, 32'd9);
        wr(2'd0, 4'hF, 32'h0, "fz stop");
        idle(2, "fz idle");

        // Byte merge, read-only COUNT, reserved slot, empty byte-enable.
        wr(2'd1, 4'hF, 32'h0, "bm clr");
        wr(2'd1, 4'b0010, 32'hAABBCCDD, "bm merge");
        rd(2'd1, v); chk("bm preset", v, 32'h0000CC00);
        wr(2'd2, 4'hF, 32'hFFFFFFFF, "bm count wr");
        wr(2'd3, 4'hF, 32'hFFFFFFFF, "bm rsvd wr");
        rd(2'd3, v); chk("bm rsvd", v, 32'd0);
        wr(2'd0, 4'h0, 32'h0000000F, "bm be0");
        rd(2'd0, v); chk("bm be0 ctrl", v, 32'd0);

        // Asynchronous reset with COUNT at 7.
        wr(2'd1, 4'hF, 32'd10, "rs preset");
        wr(2'd0, 4'hF, 32'hB, "rs en");
        waited = 0;
        while (!(m_t >= 1 && m_count == 32'd7) && waited < 30) begin
            tick("rs wait");
            waited++;
        end
        if (waited >= 30) expire("rs wait count7");
        reset = 1'b1;
        #1;
        chk("rs irq", {31'd0, bus.irq}, 32'd0);
        rd(2'd0, v); chk("rs ctrl", v, 32'd0);
        rd(2'd1, v); chk("rs preset", v, 32'd0);
        rd(2'd2, v); chk("rs count", v, 32'd0);
        model_reset();
        reset = 1'b0;
        idle(4, "rs after");

        // Random register traffic.
        for (int i = 0; i < 60; i++) begin
            r  = 2'($urandom_range(0, 3));
            be = 4'($urandom_range(0, 15));
            if (r == 2'd0) begin
                d = 32'($urandom_range(0, 15));
                d[0] = ($urandom_range(0, 3) != 0);
            end else if (r == 2'd1) begin
                d = 32'($urandom_range(0, 8));
            end else begin
                d = $urandom;
            end
            wr(r, be, d, "rnd wr");
            idle(int'($urandom_range(0, 8)), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
